fib_bcd_converter: RTL
======================

Name: fib_bcd_converter

Overview:
- Downstream display stage for the 32-bit Fibonacci term generator.
- Captures one binary term through a valid/ready handshake and converts it to packed BCD using sequential shift-add-3 (double-dabble), one bit per clock.
- Presents the decimal digits and a significant-digit count to the display/UART formatter through a second valid/ready handshake.
- When fed by the free-running generator (in_valid tied high), it samples whatever term is current each time it is ready.

Parameters:
- WIDTH, 32: binary input width; one shift cycle per bit.
- DIGITS, 10: BCD digit count; must be at least ceil(WIDTH*log10(2)); 10 covers 32 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a term to convert.
- in_ready  out  1  converter can accept a term; high only in IDLE.
- in_data  in  WIDTH  binary term; sampled only on the accepting edge.
- out_valid  out  1  out_bcd and out_ndigits are valid.
- out_ready  in  1  consumer takes the result.
- out_bcd  out  4*DIGITS  packed BCD; digit 0 is in bits [3:0]; most significant digit is in the top nibble.
- out_ndigits  out  4  number of significant decimal digits, 1..DIGITS.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, out_valid=0, out_bcd=0, out_ndigits=0.
  - Shift register and bit counter cleared.
  - Reset mid-conversion or mid-DONE discards the result; no out_valid pulse follows.
- FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE), combinational.
- IDLE:
  - On an edge with in_valid=1: load bin_reg=in_data, bcd_reg=0, cnt=WIDTH; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  1. Every 4-bit digit of bcd_reg that is >=5 gets +3 (all digits in parallel, combinational).
  2. Shift {bcd_reg, bin_reg} left by 1.
  3. cnt decrements.
  - On the edge where cnt goes 1->0: register out_bcd from the final shifted value, register out_ndigits, set out_valid=1, go to DONE.
- Latency:
  - Accepting edge = edge 0. out_valid goes high after edge WIDTH (33 edges inclusive for WIDTH=32).
  - Minimum period between accepts is WIDTH+2 cycles.
- DONE:
  - out_bcd and out_ndigits are held stable while out_valid=1 and out_ready=0 (arbitrary backpressure).
  - On an edge with out_ready=1: out_valid=0, go to IDLE; in_ready is high the following cycle.
  - No accept happens in the same cycle as the output handshake.
- in_valid and in_data are ignored outside IDLE. Input changes during SHIFT do not affect the result.
- out_ndigits = index of the most significant nonzero digit + 1. A value of 0 gives out_ndigits=1.
- Arithmetic:
  - Any digit after add-3 fits in 4 bits; no carry between digits.
  - Each output digit is always 0..9.
  - The input is converted as an unsigned value. Terms that wrapped modulo 2^WIDTH upstream are converted as-is; no overflow flag.
- out_bcd and out_ndigits change only on the edge entering DONE. Their value after a handshake is don't-care for the consumer but remains the last result.

Test Plan:
- Zero: reset, then in_data=0 with in_valid=1 -> out_valid rises after edge 32; out_bcd=0; out_ndigits=1.
- Typical term: in_data=144 -> out_bcd=40'h00_0000_0144; out_ndigits=3; exactly 33 edges from accept to out_valid.
- Full width: in_data=32'hFFFF_FFFF -> out_bcd=40'h42_9496_7295; out_ndigits=10.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_bcd stable, in_ready=0 throughout. Then one out_ready=1 cycle -> out_valid=0 next cycle and in_ready=1.
- Reset mid-op: assert rst low 16 cycles into SHIFT -> out_valid=0 and in_ready=1 immediately. Next conversion of 2971215073 -> out_bcd=40'h29_7121_5073; out_ndigits=10.
- System: connect to the Fibonacci generator with in_valid=1 and out_ready=1 -> every result equals the decimal model of the generator output at the accepting edge, with accepts spaced exactly 34 cycles apart.

Source files
------------

// File: rtl/fib_bcd_converter.sv
// rtl/fib_bcd_converter.sv - sequential binary-to-BCD converter for Fibonacci terms
//
// Purpose:
//   Accepts one WIDTH-bit unsigned term over a valid/ready handshake and converts it
//   to packed BCD with the shift-add-3 (double-dabble) method, one input bit per clock.
//   The result and its significant-digit count are offered over a second valid/ready
//   handshake and held stable under backpressure.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_valid     in_data holds a term to convert
//   in_ready     converter can accept a term (high only while idle)
//   in_data      binary term, sampled on the accepting edge only
//   out_valid    out_bcd / out_ndigits are valid
//   out_ready    consumer takes the result
//   out_bcd      packed BCD, digit 0 in bits [3:0]
//   out_ndigits  number of significant decimal digits, 1..DIGITS

`timescale 1ns/1ps

module fib_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [3:0]            out_ndigits
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     out_bcd_q, out_bcd_d;
  logic [3:0]        out_nd_q, out_nd_d;
  logic              out_valid_q, out_valid_d;

  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     bcd_shift;
  logic [3:0]        nd_shift;

  // Add-3 correction on every digit before the shift; a digit >=5 would become
  // >=10 after doubling, so +3 makes the doubling carry into the next digit.
  // The largest corrected digit is 9+3=12, so each digit stays within its nibble.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // The BCD register is the upper half of the {bcd, bin} shift chain.
  assign bcd_shift = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};

  // Significant digits: highest nonzero digit index + 1; an all-zero result still
  // shows one digit.
  always_comb begin
    nd_shift = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_shift[4*i +: 4] != 4'd0) begin
        nd_shift = 4'(i + 1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    out_bcd_d   = out_bcd_q;
    out_nd_d    = out_nd_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = in_data;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        bcd_d = bcd_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CW'(1);
        // Last bit shifted in: the shifted value is the finished result.
        if (cnt_q == CW'(1)) begin
          out_bcd_d   = bcd_shift;
          out_nd_d    = nd_shift;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        // No accept in this cycle even if in_valid is high; in_ready rises next cycle.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      out_bcd_q   <= '0;
      out_nd_q    <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      out_bcd_q   <= out_bcd_d;
      out_nd_q    <= out_nd_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign out_bcd     = out_bcd_q;
  assign out_ndigits = out_nd_q;

endmodule
